// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the 16-bit pipeline write-back register file.
// Contents:
//   DATA_W / IDX_W      datapath and register index widths
//   REG_SP .. REG_RA    indices of the special registers
//   REG_NOWRITE         index meaning "no write-back"
//   SP_RESET            stack pointer value after reset
//   is_writable(idx)    true for indices backed by a physical register (0..11)
package regfile_pkg;

  localparam int DATA_W   = 16;
  localparam int IDX_W    = 4;
  localparam int NUM_REGS = 12;

  localparam logic [IDX_W-1:0] REG_SP      = 4'd8;
  localparam logic [IDX_W-1:0] REG_IH      = 4'd9;
  localparam logic [IDX_W-1:0] REG_T       = 4'd10;
  localparam logic [IDX_W-1:0] REG_RA      = 4'd11;
  localparam logic [IDX_W-1:0] REG_NOWRITE = 4'd15;

  localparam logic [DATA_W-1:0] SP_RESET = 16'hBF00;

  // Indices 12..14 are reserved and 15 is the "no write" marker; only 0..11 exist.
  function automatic logic is_writable(input logic [IDX_W-1:0] idx);
    return (idx <= REG_RA);
  endfunction

endpackage

// File: rtl/wb_sel.sv
// Write-back select: picks load data or ALU result and decodes the write enable.
// Ports:
//   memtoreg  in   1 = select memdata, 0 = select alu
//   memdata   in   load data from MEM/WB
//   alu       in   ALU result from MEM/WB
//   wreg      in   destination index
//   wdata     out  selected write-back data
//   we        out  destination is a physical register (0..11)
module wb_sel
  import regfile_pkg::*;
(
  input  logic              memtoreg,
  input  logic [DATA_W-1:0] memdata,
  input  logic [DATA_W-1:0] alu,
  input  logic [IDX_W-1:0]  wreg,
  output logic [DATA_W-1:0] wdata,
  output logic              we
);

  assign wdata = memtoreg ? memdata : alu;
  assign we    = is_writable(wreg);

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage and architectural register file of the 16-bit pipeline.
// Commits the MEM/WB result on the rising clock edge, serves two combinational
// read ports to ID, and produces a registered "T != 0" flag for branch logic.
// Configuration macro: WB_BYPASS_EN -- when defined, a read of the register
// being written this cycle returns the write-back data (write-through).
// Ports:
//   clk          in   clock, commit on rising edge
//   rst          in   asynchronous active-low reset
//   wb_memtoreg  in   1: commit wb_memdata, 0: commit wb_alu
//   wb_memdata   in   load data
//   wb_alu       in   ALU result
//   wb_wreg      in   destination index (12..15 = no commit)
//   ra_idx       in   read port A index
//   rb_idx       in   read port B index
//   ra_data      out  read port A data (combinational)
//   rb_data      out  read port B data (combinational)
//   t_flag       out  registered (T != 0)
//   wb_commit    out  registered pulse, a commit happened on the last edge
module wb_regfile
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_memtoreg,
  input  logic [DATA_W-1:0] wb_memdata,
  input  logic [DATA_W-1:0] wb_alu,
  input  logic [IDX_W-1:0]  wb_wreg,
  input  logic [IDX_W-1:0]  ra_idx,
  input  logic [IDX_W-1:0]  rb_idx,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  output logic              t_flag,
  output logic              wb_commit
);

  logic [DATA_W-1:0] regs_r [NUM_REGS];
  logic [DATA_W-1:0] wdata_s;
  logic              we_s;
  logic [DATA_W-1:0] t_next_s;
  logic [DATA_W-1:0] ra_data_s;
  logic [DATA_W-1:0] rb_data_s;
  logic              t_flag_r;
  logic              wb_commit_r;

  wb_sel u_wb_sel (
    .memtoreg (wb_memtoreg),
    .memdata  (wb_memdata),
    .alu      (wb_alu),
    .wreg     (wb_wreg),
    .wdata    (wdata_s),
    .we       (we_s)
  );

  // Register storage: one flop bank per register so no RAM is inferred.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (IDX_W'(i) == REG_SP) begin
          regs_r[i] <= SP_RESET;
        end else begin
          regs_r[i] <= {DATA_W{1'b0}};
        end
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (we_s && (wb_wreg == IDX_W'(i))) begin
          regs_r[i] <= wdata_s;
        end else begin
          regs_r[i] <= regs_r[i];
        end
      end
    end
  end

  // Value T will hold after this edge, so t_flag tracks it with one cycle latency.
  always_comb begin
    t_next_s = regs_r[REG_T];
    if (we_s && (wb_wreg == REG_T)) begin
      t_next_s = wdata_s;
    end else begin
      t_next_s = regs_r[REG_T];
    end
  end

  // Registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      t_flag_r    <= 1'b0;
      wb_commit_r <= 1'b0;
    end else begin
      t_flag_r    <= (t_next_s != {DATA_W{1'b0}});
      wb_commit_r <= we_s;
    end
  end

  // Read port A: reserved indices read as zero.
  always_comb begin
    ra_data_s = {DATA_W{1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ra_idx == IDX_W'(i)) begin
        ra_data_s = regs_r[i];
      end else begin
        ra_data_s = ra_data_s;
      end
    end
`ifdef WB_BYPASS_EN
    // we_s implies wb_wreg <= 11, so reserved indices never take the bypass.
    if (we_s && (ra_idx == wb_wreg)) begin
      ra_data_s = wdata_s;
    end else begin
      ra_data_s = ra_data_s;
    end
`endif
  end

  // Read port B: same structure as port A, fully independent.
  always_comb begin
    rb_data_s = {DATA_W{1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rb_idx == IDX_W'(i)) begin
        rb_data_s = regs_r[i];
      end else begin
        rb_data_s = rb_data_s;
      end
    end
`ifdef WB_BYPASS_EN
    if (we_s && (rb_idx == wb_wreg)) begin
      rb_data_s = wdata_s;
    end else begin
      rb_data_s = rb_data_s;
    end
`endif
  end

  assign ra_data   = ra_data_s;
  assign rb_data   = rb_data_s;
  assign t_flag    = t_flag_r;
  assign wb_commit = wb_commit_r;

endmodule
